// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
//   OVL_ON / OVL_OFF : values of the overlap select input
//   SEQ_DEF_PAT      : default 4-bit pattern loaded at reset
//   clog2            : ceiling log2, used to size the fill counter
package seq_det_pkg;

  localparam logic       OVL_ON      = 1'b1;
  localparam logic       OVL_OFF     = 1'b0;
  localparam logic [3:0] SEQ_DEF_PAT = 4'b1011;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear, wins over inc
//   inc      : increment request; holds at all-ones instead of wrapping
//   q        : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with a runtime-loadable PAT_W-bit pattern.
//   clk, rst    : clock and synchronous active-high reset
//   din_valid   : qualifies din; window advances only when high
//   din         : serial data bit (first bit in time lands in pattern MSB)
//   pat_load    : strobe to latch pat_in; clears window, drops that cycle's bit
//   pat_in      : new pattern
//   overlap     : 1 = overlapping detection, 0 = non-overlapping
//   cnt_clr     : synchronous clear of match_count (wins over a hit)
//   match       : registered one-cycle pulse after the completing bit
//   match_count : saturating match counter
//   busy        : registered, high while the window holds any valid bit
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned           PAT_W   = 4,
  parameter int unsigned           CNT_W   = 8,
  parameter logic [PAT_W-1:0]      RST_PAT = PAT_W'(SEQ_DEF_PAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  localparam int unsigned      FILL_W    = clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  win_q, win_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic              busy_q, busy_d;

  logic [PAT_W-1:0]  win_acc;
  logic [FILL_W-1:0] fill_acc;
  logic              hit;

  always_comb begin
    pat_d    = pat_q;
    win_d    = win_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    hit      = 1'b0;
    win_acc  = {win_q[PAT_W-2:0], din};
    fill_acc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;

    if (pat_load) begin
      pat_d  = pat_in;
      win_d  = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hit     = (fill_acc == FILL_FULL) && (win_acc == pat_q);
      match_d = hit;
      win_d   = win_acc;
      // Non-overlapping: window contents stay but are treated as empty.
      fill_d  = (hit && (overlap == OVL_OFF)) ? '0 : fill_acc;
    end

    busy_d = (fill_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= RST_PAT;
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      busy_q  <= busy_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (hit),
    .q   (match_count)
  );

  assign match = match_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst, din_valid, din, pat_load, overlap, cnt_clr;
  logic [3:0] pat_in;
  logic       match, busy;
  logic [7:0] match_count;
  logic       match2, busy2;
  logic [1:0] match_count2;

  int errors = 0;
  int checks = 0;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .cnt_clr(cnt_clr), .match(match), .match_count(match_count), .busy(busy)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .cnt_clr(cnt_clr), .match(match2), .match_count(match_count2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, i[0]);
      checks++;
      if (match !== 1'b0 || match_count !== 8'd0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: match=%b cnt=%0d busy=%b expected 0/0/0", match, match_count, busy);
      end
    end
    rst = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (match !== 1'b0 || match_count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: match=%b cnt=%0d busy=%b expected 0/0/0", match, match_count, busy);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] mexp = 7'b0001001;
    do_reset();
    overlap = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i]);
      checks++;
      if (match !== mexp[i]) begin
        errors++;
        $display("FAIL overlap_match bit%0d: got %b expected %b", 7 - i, match, mexp[i]);
      end
    end
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL overlap_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_non_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] mexp = 7'b0001000;
    do_reset();
    overlap = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i]);
      checks++;
      if (match !== mexp[i]) begin
        errors++;
        $display("FAIL nonovl_match bit%0d: got %b expected %b", 7 - i, match, mexp[i]);
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL nonovl_count: got %0d expected 1", match_count);
    end
    checks++;
    if (dut.fill_q !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nonovl_fill: fill=%0d busy=%b expected 3/1", dut.fill_q, busy);
    end
  endtask

  task automatic test_gaps_and_load();
    logic [6:0] vld  = 7'b1100011;
    logic [6:0] bits = 7'b1000011;
    logic [6:0] mexp = 7'b0000001;
    logic [3:0] b2   = 4'b0110;
    logic [3:0] m2   = 4'b0001;
    do_reset();
    overlap = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      step(vld[i], bits[i]);
      checks++;
      if (match !== mexp[i]) begin
        errors++;
        $display("FAIL gap_match step%0d: got %b expected %b", 7 - i, match, mexp[i]);
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL gap_count: got %0d expected 1", match_count);
    end
    pat_load = 1'b1;
    pat_in   = 4'b0110;
    step(1'b1, 1'b0);
    pat_load = 1'b0;
    checks++;
    if (busy !== 1'b0 || match !== 1'b0) begin
      errors++;
      $display("FAIL load_clear: busy=%b match=%b expected 0/0", busy, match);
    end
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, b2[i]);
      checks++;
      if (match !== m2[i]) begin
        errors++;
        $display("FAIL load_match bit%0d: got %b expected %b", 4 - i, match, m2[i]);
      end
    end
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL load_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_saturation_clear();
    int exp_c;
    do_reset();
    overlap  = 1'b1;
    pat_load = 1'b1;
    pat_in   = 4'b1111;
    step(1'b0, 1'b0);
    pat_load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1);
      exp_c = (k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3);
      checks++;
      if (match2 !== (k >= 4) || match_count2 !== 2'(exp_c)) begin
        errors++;
        $display("FAIL sat bit%0d: match=%b cnt=%0d expected %b/%0d", k, match2, match_count2, k >= 4, exp_c);
      end
    end
    checks++;
    if (match_count !== 8'd7) begin
      errors++;
      $display("FAIL sat_wide_count: got %0d expected 7", match_count);
    end
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    cnt_clr = 1'b0;
    checks++;
    if (match2 !== 1'b1 || match_count2 !== 2'd0 || match_count !== 8'd0) begin
      errors++;
      $display("FAIL clr_vs_hit: match=%b cnt2=%0d cnt=%0d expected 1/0/0", match2, match_count2, match_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre  = 3'b101;
    logic [3:0] post = 4'b1011;
    logic [3:0] mexp = 4'b0001;
    pat_load = 1'b1;
    pat_in   = 4'b1111;
    step(1'b0, 1'b0);
    pat_load = 1'b0;
    for (int i = 2; i >= 0; i--) step(1'b1, pre[i]);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || match !== 1'b0 || match_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b match=%b cnt=%0d expected 0/0/0", busy, match, match_count);
    end
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, post[i]);
      checks++;
      if (match !== mexp[i]) begin
        errors++;
        $display("FAIL midrst_match bit%0d: got %b expected %b", 4 - i, match, mexp[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; pat_load = 1'b0;
    pat_in = 4'b0000; overlap = 1'b1; cnt_clr = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_gaps_and_load();
    test_saturation_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-sequence detector for the Sequence_Detector design, generalising the fixed-pattern detector datapath. It detects a runtime-loadable PAT_W-bit pattern in a gated serial stream, with selectable overlapping or non-overlapping detection. It produces a registered one-cycle match pulse and keeps a saturating match counter. It sits between the serial input conditioning logic and the downstream status/display logic.

Parameters:
PAT_W, 4, pattern length in bits (legal range 2..16).
CNT_W, 8, width of the saturating match counter.
RST_PAT, 4'b1011 (sized PAT_W), pattern value loaded at reset.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
din_valid  in  1  qualifies din; state advances only when high
din  in  1  serial data bit
pat_load  in  1  one-cycle strobe: latch pat_in as new pattern
pat_in  in  PAT_W  new pattern; MSB is the first bit in time
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cnt_clr  in  1  synchronous clear of match_count
match  out  1  one-cycle pulse: pattern completed
match_count  out  CNT_W  saturating count of matches
busy  out  1  high while the window holds at least one valid bit (fill != 0)

Behaviour:
- Reset (rst=1 at clock edge):
  - pattern register = RST_PAT; shift window = 0; fill = 0.
  - match = 0; match_count = 0; busy = 0.
  - rst overrides all other inputs, including mid-stream.
- Registers:
  - pat_r[PAT_W-1:0].
  - win[PAT_W-1:0] shift window; the newest bit enters at LSB.
  - fill[clog2(PAT_W+1)-1:0] saturating at PAT_W.
  - match_count.
- Accepted bit (din_valid=1, pat_load=0):
  - win_n = {win[PAT_W-2:0], din}; fill_n = min(fill+1, PAT_W).
  - hit = (fill_n == PAT_W) && (win_n == pat_r).
  - match is registered: match = hit on the edge that accepts the completing bit, so it is high for exactly the following cycle.
  - On hit, overlap=1: win/fill keep win_n/PAT_W, so the next bit may complete another match.
  - On hit, overlap=0: fill cleared to 0 (win still takes win_n; its contents are ignored until refilled). The next match needs PAT_W fresh bits.
- din_valid=0: win, fill and match_count hold; match = 0.
- pat_load=1:
  - pat_r = pat_in; win = 0; fill = 0; match = 0.
  - The bit presented that cycle is discarded even if din_valid=1.
  - pat_load has priority over din_valid.
- overlap is sampled only on the hit cycle; changing it mid-stream is legal.
- match_count:
  - Increments on each hit; saturates at 2^CNT_W-1, no wrap.
  - cnt_clr=1 sets it to 0. If cnt_clr and a hit occur in the same cycle, the result is 0 (clear wins); match still pulses.
  - match_count is registered, updating on the same edge that asserts match.
- busy = (fill != 0), registered.
- Latency: 1 cycle from the accepted completing bit to match/match_count.

Decomposition:
- Package seq_det_pkg:
  - constants OVL_ON=1'b1 and OVL_OFF=1'b0.
  - function clog2 for sizing fill.
  - default pattern constant SEQ_DEF_PAT=4'b1011.
- One natural sub-module: sat_counter #(W) (clk, rst, clr, inc, q), used for match_count. The rest stays in the top module.

Test Plan:
1. Reset/defaults: assert rst 2 cycles with din_valid=1 toggling -> match=0, match_count=0, busy=0; pattern=1011.
2. Overlap: overlap=1, stream 1,0,1,1,0,1,1 (valid every cycle) -> match pulses after bit 4 and bit 7; match_count=2.
3. Non-overlap: same stream, overlap=0 -> single pulse after bit 4; match_count=1; fill=3 at end.
4. Gaps and load: stream 1,0,(valid=0 x3),1,1 -> match after the last 1, with gaps not breaking the sequence. Then pat_load with pat_in=0110 while din_valid=1 -> that bit is dropped, busy=0; stream 0,1,1,0 -> match, count increments.
5. Saturation/clear: CNT_W=2, pattern 1111, overlap=1, feed ten 1s -> match pulses on bits 4..10 (7 pulses); count sticks at 3. Assert cnt_clr coincident with a hit -> count=0 and match=1.
6. Reset mid-operation: after bits 1,0,1, assert rst for 1 cycle, then feed 1 -> no match; the full pattern must then be resent; pat_r is back to RST_PAT.
